// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the multi-port register file.
//   - Clear sequencer state encoding.
//   - Default datapath width constants.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    RF_IDLE  = 2'd0,
    RF_SWEEP = 2'd1,
    RF_DONE  = 2'd2
  } rf_state_e;

  // True when an enabled write port targets the given address.
  function automatic logic rf_hit(input logic en, input logic [31:0] waddr,
                                  input logic [31:0] addr);
    return en && (waddr == addr);
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: hardware clear sequencer for register_file_mp.
// On clr_req it walks a counter over every address, strobing clr_we
// with clr_addr = counter for DEPTH cycles. It then raises clr_done for one cycle.
// clr_busy and clr_done are flops loaded from the next state,
// so they are glitch-free and track SWEEP/DONE exactly.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rf_state_e         state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              busy_reg, done_reg;

  // State, counter and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RF_IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next == RF_SWEEP);
      done_reg  <= (state_next == RF_DONE);
    end
  end

  // Next-state, counter update and clear-write strobe
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_we     = 1'b0;
    clr_addr   = cnt_reg;
    case (state_reg)
      RF_IDLE: begin
        if (clr_req) begin
          state_next = RF_SWEEP;
          cnt_next   = '0;
        end
      end
      RF_SWEEP: begin
        clr_we   = 1'b1;
        // Wraps to 0 on the last address; harmless since SWEEP is left.
        cnt_next = cnt_reg + ADDR_W'(1);
        if (cnt_reg == LAST_ADDR) begin
          state_next = RF_DONE;
        end
      end
      RF_DONE: begin
        state_next = RF_IDLE;
      end
      default: begin
        state_next = RF_IDLE;
      end
    endcase
  end

  assign clr_busy = busy_reg;
  assign clr_done = done_reg;

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file for the MIPS MCU datapath.
// Features:
//   - Two write ports; port 1 wins on an address collision.
//   - NUM_RD combinational read ports.
//   - Optional hardwired-zero register 0 (ZERO_REG).
//   - Hardware clear sweep driven by rf_clear_seq.
// Optional macro RF_BYPASS_EN:
//   - Same-cycle write-to-read forwarding on every read port.
//   - When undefined, reads show the array contents as they were before the edge.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_block;
  logic [DATA_W-1:0] reg_view [DEPTH];

  rf_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Functional writes are suppressed for the whole sweep and its DONE cycle.
  assign wr_block = clr_busy | clr_done;

  genvar gi;

  // Storage: one register per address.
  // Each register has its own clear/priority write selection.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg, q_next;

      // Select sweep clear, port 1, port 0 or hold for this register
      always_comb begin
        q_next = q_reg;
        if (clr_we && (clr_addr == ADDR_W'(gi))) begin
          q_next = '0;
        end else if (!wr_block) begin
          if (we1 && (waddr1 == ADDR_W'(gi))) begin
            q_next = wdata1;
          end else if (we0 && (waddr0 == ADDR_W'(gi))) begin
            q_next = wdata0;
          end
        end
        if ((ZERO_REG != 0) && (gi == 0)) begin
          q_next = '0;
        end
      end

      // Register storage with asynchronous clear
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else begin
          q_reg <= q_next;
        end
      end

      assign reg_view[gi] = q_reg;
    end
  endgenerate

  // Read ports: independent combinational muxes.
  // Each port has optional forwarding and zero-register masking.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_word;

      assign ra = raddr[gi*ADDR_W +: ADDR_W];

      // Array lookup, then forwarding, then zero-register override
      always_comb begin
        rd_word = reg_view[ra];
`ifdef RF_BYPASS_EN
        if (!wr_block) begin
          if (rf_hit(we1, 32'(waddr1), 32'(ra))) begin
            rd_word = wdata1;
          end else if (rf_hit(we0, 32'(waddr0), 32'(ra))) begin
            rd_word = wdata0;
          end
        end
`endif
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rd_word = '0;
        end
      end

      assign rdata[gi*DATA_W +: DATA_W] = rd_word;
    end
  endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed self-checking bench for register_file_mp.
// Runs with default parameters (32x32, two read ports, ZERO_REG=1).
// Also runs with or without RF_BYPASS_EN defined.
module tb_register_file_mp;
  import rf_pkg::*;

  localparam int DW = RF_DATA_W;
  localparam int AW = RF_ADDR_W;
  localparam int NR = 2;

  logic             tb_clk = 1'b0;
  logic             rst_n  = 1'b0;
  logic             we0, we1, clr_req;
  logic [AW-1:0]    waddr0, waddr1;
  logic [DW-1:0]    wdata0, wdata1;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic             clr_busy, clr_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 tb_clk = ~tb_clk;

  register_file_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)
  ) dut (
    .clk      (tb_clk),
    .rst_n    (rst_n),
    .we0      (we0),
    .waddr0   (waddr0),
    .wdata0   (wdata0),
    .we1      (we1),
    .waddr1   (waddr1),
    .wdata1   (wdata1),
    .raddr    (raddr),
    .rdata    (rdata),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return rdata[k*DW +: DW];
  endfunction

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    raddr[k*AW +: AW] = a;
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we0 = 1'b1; waddr0 = a; wdata0 = d;
    tick();
    we0 = 1'b0;
  endtask

  // Cycle-bounded watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int done_seen;
    we0 = 0; we1 = 0; clr_req = 0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    raddr = '0;

    // 1: reset state
    #12;
    set_ra(0, 5'd0); set_ra(1, 5'd31);
    #1;
    check("reset_rd0_addr0", 64'(rd(0)), 64'h0);
    check("reset_rd1_addr31", 64'(rd(1)), 64'h0);
    check("reset_busy", 64'(clr_busy), 64'h0);
    check("reset_done", 64'(clr_done), 64'h0);
    @(negedge tb_clk);
    rst_n = 1'b1;
    tick();

    // 2: single writes on each port
    we1 = 1; waddr1 = 5'd5; wdata1 = 32'hDEADBEEF;
    tick();
    we1 = 0;
    wr0(5'd10, 32'hCAFECAFE);
    set_ra(0, 5'd5); set_ra(1, 5'd10);
    #1;
    check("wr1_reg5", 64'(rd(0)), 64'hDEADBEEF);
    check("wr0_reg10", 64'(rd(1)), 64'hCAFECAFE);

    // 3: collision, dual write, zero register
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'h11111111;
    we1 = 1; waddr1 = 5'd7; wdata1 = 32'h22222222;
    tick();
    we0 = 1; waddr0 = 5'd12; wdata0 = 32'h0C0C0C0C;
    we1 = 1; waddr1 = 5'd13; wdata1 = 32'h0D0D0D0D;
    tick();
    we0 = 0; we1 = 0;
    set_ra(0, 5'd7);
    #1;
    check("collision_reg7", 64'(rd(0)), 64'h22222222);
    set_ra(0, 5'd12); set_ra(1, 5'd13);
    #1;
    check("dual_wr_reg12", 64'(rd(0)), 64'h0C0C0C0C);
    check("dual_wr_reg13", 64'(rd(1)), 64'h0D0D0D0D);
    we1 = 1; waddr1 = 5'd0; wdata1 = 32'h12345678;
    set_ra(0, 5'd0);
    #1;
    check("zero_reg_same_cycle", 64'(rd(0)), 64'h0);
    tick();
    we1 = 0;
    #1;
    check("zero_reg_after", 64'(rd(0)), 64'h0);

    // 4: fill with index, then sweep
    for (int i = 0; i < 32; i++) wr0(AW'(i), DW'(i));
    set_ra(0, 5'd31); set_ra(1, 5'd17);
    #1;
    check("fill_reg31", 64'(rd(0)), 64'd31);
    check("fill_reg17", 64'(rd(1)), 64'd17);
    clr_req = 1;
    tick();
    clr_req = 0;
    n = 0;
    while (clr_busy === 1'b1 && n < 40) begin
      n++;
      if (n == 10) begin
        set_ra(0, 5'd5); set_ra(1, 5'd20);
        #1;
        check("sweep_partial_reg5", 64'(rd(0)), 64'h0);
        check("sweep_partial_reg20", 64'(rd(1)), 64'd20);
        we0 = 1; waddr0 = 5'd2; wdata0 = 32'h00000BAD;
      end
      if (n == 11) we0 = 0;
      tick();
    end
    we0 = 0;
    check("sweep_busy_cycles", 64'(n), 64'd32);
    check("sweep_done_pulse", 64'(clr_done), 64'h1);
    tick();
    check("sweep_done_cleared", 64'(clr_done), 64'h0);
    check("sweep_busy_cleared", 64'(clr_busy), 64'h0);
    for (int i = 0; i < 32; i++) begin
      set_ra(0, AW'(i));
      #1;
      check($sformatf("post_sweep_reg%0d", i), 64'(rd(0)), 64'h0);
    end

    // 5: reset asserted mid-sweep
    wr0(5'd20, 32'h20202020);
    wr0(5'd31, 32'h31313131);
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int c = 1; c < 10; c++) tick();
    check("midreset_busy_before", 64'(clr_busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy_async", 64'(clr_busy), 64'h0);
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (clr_done === 1'b1) done_seen++;
    end
    @(negedge tb_clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (clr_done === 1'b1) done_seen++;
    end
    check("midreset_no_done", 64'(done_seen), 64'h0);
    check("midreset_busy_idle", 64'(clr_busy), 64'h0);
    set_ra(0, 5'd20); set_ra(1, 5'd31);
    #1;
    check("midreset_reg20", 64'(rd(0)), 64'h0);
    check("midreset_reg31", 64'(rd(1)), 64'h0);

    // 6: read during write of the same address
    wr0(5'd9, 32'h99999999);
    set_ra(0, 5'd9);
    we0 = 1; waddr0 = 5'd9; wdata0 = 32'hA5A5A5A5;
    #1;
`ifdef RF_BYPASS_EN
    check("same_cycle_read_reg9", 64'(rd(0)), 64'hA5A5A5A5);
`else
    check("same_cycle_read_reg9", 64'(rd(0)), 64'h99999999);
`endif
    tick();
    we0 = 0;
    #1;
    check("next_cycle_read_reg9", 64'(rd(0)), 64'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
